// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: base opcodes, immediate-format codes and fetch FSM encoding.
// The immediate generator decodes imm_select with these same codes.
package riscv_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'b000,
        IMM_I     = 3'b001,
        IMM_S     = 3'b010,
        IMM_B     = 3'b011,
        IMM_U     = 3'b100,
        IMM_J     = 3'b101,
        IMM_SHAMT = 3'b110
    } imm_sel_t;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_VALID = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/imm_select_decoder.sv
// Combinational opcode decode into immediate-format code and illegal-opcode flag.
// An empty instruction register reports IMM_NONE and no illegal opcode.
module imm_select_decoder
    import riscv_pkg::*;
(
    input  logic       inst_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [2:0] imm_select,
    output logic       illegal_op
);

    imm_sel_t sel;

    always_comb begin
        sel        = IMM_NONE;
        illegal_op = 1'b0;
        if (inst_valid) begin
            case (opcode)
                OP_REG:                  sel = IMM_NONE;
                OP_LOAD, OP_JALR:        sel = IMM_I;
                OP_IMM:                  sel = (funct3 == F3_SLL || funct3 == F3_SR) ? IMM_SHAMT : IMM_I;
                OP_STORE:                sel = IMM_S;
                OP_BRANCH:               sel = IMM_B;
                OP_LUI, OP_AUIPC:        sel = IMM_U;
                OP_JAL:                  sel = IMM_J;
                default:                 illegal_op = 1'b1;
            endcase
        end
    end

    assign imm_select = sel;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: request a word at pc, hold it until retire,
// then advance pc by 4 or redirect to an aligned branch target.
//
// state    | meaning
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_VALID | instruction register live, waiting for stall=0 to retire
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [24:0] instruction_part,
    output logic [2:0]  imm_select,
    output logic        illegal_op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_t state, state_next;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         retire;

    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (imem_ack) state_next = ST_VALID;
            ST_VALID: if (!stall)   state_next = ST_FETCH;
            default:                state_next = ST_FETCH;
        endcase
    end

    // Outputs are gated by RESET so nothing is requested or presented while it is held.
    always_comb begin
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        if (!RESET) begin
            imem_req   = (state == ST_FETCH);
            inst_valid = (state == ST_VALID);
        end
    end

    assign retire = (state == ST_VALID) && !stall;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q   <= RESET_PC;
            inst_q <= INST_NOP;
        end else begin
            if (state == ST_FETCH && imem_ack)
                inst_q <= imem_rdata;
            if (retire)
                pc_q <= branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
        end
    end

    assign pc               = pc_q;
    assign pc_plus4         = pc_q + 32'd4;
    assign imem_addr        = pc_q;
    assign instruction      = inst_q;
    assign instruction_part = inst_q[31:7];

    imm_select_decoder u_imm_select_decoder (
        .inst_valid (inst_valid),
        .opcode     (inst_q[6:0]),
        .funct3     (inst_q[14:12]),
        .imm_select (imm_select),
        .illegal_op (illegal_op)
    );

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  memory has imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port stall  input  1  downstream holds the current instruction.
REQ-009 SHALL have port branch_taken  input  1  redirect the next PC at retire.
REQ-010 SHALL have port branch_target  input  32  redirect address.
REQ-011 SHALL have port inst_valid  output  1  instruction register holds a live instruction.
REQ-012 SHALL have port instruction  output  32  instruction register contents.
REQ-013 SHALL have port instruction_part  output  25  instruction[31:7], feeding the immediate generator.
REQ-014 SHALL have port imm_select  output  3  immediate-format code for the immediate generator.
REQ-015 SHALL have port illegal_op  output  1  live instruction has an unrecognised opcode.
REQ-016 SHALL have ports pc and pc_plus4  output  32 each  address of the live instruction, and that address + 4.

Function
REQ-017 SHALL implement a two-state FSM: FETCH (imem_req=1, waiting for imem_ack) and VALID (inst_valid=1, waiting for retire).
REQ-018 In FETCH, on imem_ack=1: SHALL latch imem_rdata into the instruction register and enter VALID next cycle; imem_ack in the first request cycle is legal, giving a 1-cycle minimum fetch latency.
REQ-019 In FETCH without imem_ack: SHALL hold imem_req=1 and imem_addr stable.
REQ-020 imem_ack SHALL be ignored in VALID.
REQ-021 In VALID with stall=1: SHALL hold the instruction, pc and every output unchanged.
REQ-022 In VALID with stall=0 (retire): SHALL load pc with {branch_target[31:2],2'b00} if branch_taken=1, else pc+4, and enter FETCH.
REQ-023 branch_taken SHALL be sampled only at retire; in FETCH, or in VALID with stall=1, it SHALL be ignored.
REQ-024 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 imm_select SHALL decode opcode instruction[6:0]: 0110011->000; 0000011, 1100111, and 0010011 with funct3 other than 001/101 ->001; 0010011 with funct3 001/101 ->110; 0100011->010; 1100011->011; 0110111, 0010111->100; 1101111->101.
REQ-026 Any other opcode SHALL give imm_select=000 and illegal_op=1.
REQ-027 When inst_valid=0, imm_select SHALL be 000 and illegal_op 0.
REQ-028 The minimum throughput SHALL be one instruction per two cycles.

Reset
REQ-029 While RESET=1: pc=RESET_PC, state=FETCH, imem_req=0, inst_valid=0, instruction=32'h0000_0013 (NOP); imem_ack ignored.
REQ-030 In the first cycle after RESET falls, SHALL assert imem_req with imem_addr=RESET_PC.
REQ-031 Reset asserted mid-fetch or mid-stall SHALL abandon the operation with no latch and no PC update.

Structure
REQ-032 Opcode constants, imm_select codes (000..110, shared with the immediate generator) and the FSM state encoding SHALL live in shared package riscv_pkg.
REQ-033 The opcode-to-imm_select/illegal_op decode SHALL be a combinational sub-module named imm_select_decoder.

Verification
REQ-034 Reset, then imem_ack in the first request cycle with rdata 32'h00500093 -> imem_addr=0; inst_valid high on the next cycle; imm_select=001; instruction_part=25'h00A001.
REQ-035 imem_ack delayed 3 cycles -> imem_req and imem_addr held for 3 cycles; latch on the 4th cycle.
REQ-036 In VALID, stall=1 for 2 cycles, then stall=0 with branch_taken=1 and branch_target=32'h0000_0103 -> outputs held while stalled; next imem_addr=32'h0000_0100.
REQ-037 pc=32'hFFFF_FFFC, retire without branch -> next imem_addr=32'h0000_0000.
REQ-038 Sweep rdata over opcodes 0110011, 0100011, 1100011, 0110111, 1101111, 0010011/funct3 101, and 1111111 -> imm_select 000, 010, 011, 100, 101, 110, and 000 with illegal_op=1.
REQ-039 RESET pulsed while in FETCH with imem_ack=1 -> no latch; inst_valid=0; pc=RESET_PC.
